gf_mult_ds: RTL
===============

# gf_mult_ds

Digit-serial GF(2^M) multiplier with runtime operands and a runtime field polynomial. It generalises the fixed-operand bit-serial multiplier in two ways: both multiplicands are loaded per operation, and D bits of the second operand are consumed per cycle. It sits between the OFDM datapath's symbol producers (RS encoder, scramblers) and any consumer that needs field products. Valid/ready handshakes on both sides allow back-to-back operations with backpressure.

## Interface
- M, 8: field degree, GF(2^M); M >= 2.
- D, 1: digit size in bits per cycle; 1 <= D <= M; M % D must be 0, otherwise elaboration fails.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept an operand set.
- a  in  M  first multiplicand, polynomial basis, bit i = coeff of x^i.
- b  in  M  second multiplicand, consumed MSB-first, D bits per cycle.
- poly  in  M  field polynomial low coefficients; x^M is implicit (0x1D = x^8+x^4+x^3+x^2+1).
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- c  out  M  product a*b mod (x^M + poly).
- busy  out  1  high in BUSY state.

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch a, poly, b into a_r, p_r, b_r;
  - clear acc to 0 and cnt to 0;
  - go to BUSY.
- BUSY: each cycle performs D MSB-first steps combinationally. For j = 0..D-1:
  - t = b_r[M-1-j];
  - acc = (acc<<1 dropped to M bits) ^ (acc[M-1] ? p_r : 0) ^ (t ? a_r : 0).
  - Then b_r shifts left by D (zero fill) and cnt increments.
  - When cnt reaches M/D-1, the final update also moves the FSM to DONE.
- DONE: out_valid=1, c=acc, held stable until out_ready. On out_valid&out_ready, go to IDLE.
- Counter width: clog2(M/D)+1. All arithmetic is XOR/AND over GF(2); no carries.
- in_valid is ignored outside IDLE, and operands are not sampled then.
- Inputs a/b/poly may change freely after acceptance; only latched copies are used.
- poly with bit pattern making a reducible polynomial is not checked; the result is still a*b mod (x^M+poly).

## Timing
- Reset values:
  - in_ready=1;
  - out_valid=0;
  - busy=0;
  - c=0 (acc=0).
- Reset asserted mid-operation aborts immediately (asynchronously). No product is emitted for the aborted operation.
- Latency: accept on edge k; acc updates on edges k+1..k+M/D; out_valid rises after edge k+M/D. Latency = M/D cycles.
- Output transfer on edge t returns the FSM to IDLE. in_ready is high from t, so the next accept is possible at t+1.
- Throughput: one product per M/D+2 cycles with out_ready held high.
- in_ready and out_valid are never high in the same cycle. busy = (state==BUSY).
- out_valid depends on state only, never combinationally on out_ready. in_ready depends on state only.
- c reads acc at all times, including intermediate values in BUSY. Consumers must qualify c with out_valid.

## Test plan
- M=8, D=1, poly=0x1D: a=0x02, b=0x80 -> c=0x1D. out_valid rises exactly 8 cycles after accept.
- M=8, D=1, poly=0x1B: a=0x53, b=0xCA -> c=0x01. Also a=0x57, b=0x83 -> c=0xC1. Also a=0xA5, b=0x01 -> c=0xA5. Also a=0x00, b=0xFF -> c=0x00.
- Repeat the previous vectors with D=2, 4, 8 -> identical c. Latency is 4, 2 and 1 cycles respectively. Random 1000 operands checked against a reference model for each D.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> c stable, out_valid=1, in_ready=0. A new in_valid during DONE is ignored. Release -> IDLE next cycle, then the held operand is accepted.
- Change a/b/poly on the cycle after accept -> the product is still from the latched values.
- Assert reset 3 cycles into BUSY (M=8, D=1) -> out_valid=0, in_ready=1, busy=0, c=0 immediately. The next operation a=0x02, b=0x80, poly=0x1D gives 0x1D with nominal latency.

Source files
------------

// File: rtl/gf_mult_ds.sv
`timescale 1ns/1ps
// gf_mult_ds
// Digit-serial GF(2^M) multiplier with runtime operands and a runtime field
// polynomial. Each operation multiplies a by b modulo (x^M + poly). b is
// consumed MSB-first, D bits per cycle, so one product takes M/D cycles in
// BUSY. Valid/ready handshakes on both sides allow back-to-back operations
// with backpressure.
//
// Parameters
//   M : field degree (M >= 2)
//   D : digit size in bits per cycle (1 <= D <= M, M % D == 0)
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   in_valid  in   operand set presented on a/b/poly
//   in_ready  out  high in IDLE; operand set accepted when both high
//   a         in   first multiplicand, polynomial basis (bit i = x^i)
//   b         in   second multiplicand, consumed MSB-first
//   poly      in   field polynomial low coefficients, x^M implicit
//   out_valid out  high in DONE; product on c
//   out_ready in   consumer accepts product
//   c         out  accumulator; the product when out_valid is high
//   busy      out  high in BUSY
module gf_mult_ds #(
  parameter int M = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [M-1:0] poly,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] c,
  output logic         busy
);

  localparam int NDIG  = M / D;
  localparam int CNT_W = $clog2(NDIG) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  generate
    if ((M < 2) || (D < 1) || (D > M) || ((M % D) != 0)) begin : g_bad_params
      $error("gf_mult_ds: need M >= 2, 1 <= D <= M and M divisible by D");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [M-1:0]     acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [M-1:0]     a_q,     a_d;
  logic [M-1:0]     p_q,     p_d;
  logic [M-1:0]     b_q,     b_d;

  // D Horner steps of the interleaved multiply/reduce. Each step multiplies
  // the accumulator by x (reducing the bit shifted out of x^(M-1) with the
  // field polynomial) and adds a when the current b digit bit is set.
  function automatic logic [M-1:0] digit_step(
    input logic [M-1:0] acc_in,
    input logic [M-1:0] a_in,
    input logic [M-1:0] p_in,
    input logic [D-1:0] dig
  );
    logic [M-1:0] r;
    r = acc_in;
    for (int j = 0; j < D; j++) begin
      r = {r[M-2:0], 1'b0} ^ ({M{r[M-1]}} & p_in) ^ ({M{dig[D-1-j]}} & a_in);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    b_d     = b_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          p_d     = poly;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d = digit_step(acc_q, a_q, p_q, b_q[M-1 -: D]);
        b_d   = b_q << D;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and accumulator: cleared asynchronously so an abort is immediate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand copies: only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    p_q <= p_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign c         = acc_q;

endmodule
